// File: rtl/change_fsmd.sv
// Greedy change pay-out FSMD: issues quarters, dimes, then nickels over a req/ack handshake.
// Optional COIN_COUNT_EN adds a saturating coin_count output of coins issued per transaction.
module change_fsmd #(
  parameter int W    = 8,
  parameter int QVAL = 25,
  parameter int DVAL = 10,
  parameter int NVAL = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] amount,
  input  logic         coin_ack,
  output logic         q_out,
  output logic         d_out,
  output logic         n_out,
  output logic         busy,
  output logic         done,
  output logic         err
`ifdef COIN_COUNT_EN
  ,
  output logic [7:0]   coin_count
`endif
);

  typedef enum logic [1:0] {IDLE, SEL, ISSUE, DONE} state_t;
  typedef enum logic [1:0] {S_NONE, S_Q, S_D, S_N} sel_t;

  localparam logic [W-1:0] QV = W'(QVAL);
  localparam logic [W-1:0] DV = W'(DVAL);
  localparam logic [W-1:0] NV = W'(NVAL);

  state_t       state, state_nx;
  sel_t         sel, sel_nx;
  logic [W-1:0] rem, rem_nx;
  logic [W-1:0] coin_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= S_NONE;
      rem   <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      rem   <= rem_nx;
    end
  end

  always_comb begin
    coin_val = '0;
    case (sel)
      S_Q:     coin_val = QV;
      S_D:     coin_val = DV;
      S_N:     coin_val = NV;
      default: coin_val = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    rem_nx   = rem;
    case (state)
      IDLE: if (start) begin
        rem_nx   = amount;
        state_nx = SEL;
      end
      SEL: begin
        // selection guarantees rem >= coin value, so the subtract never wraps
        state_nx = ISSUE;
        if (rem >= QV)      sel_nx = S_Q;
        else if (rem >= DV) sel_nx = S_D;
        else if (rem >= NV) sel_nx = S_N;
        else begin
          sel_nx   = S_NONE;
          state_nx = DONE;
        end
      end
      ISSUE: if (coin_ack) begin
        rem_nx   = rem - coin_val;
        state_nx = SEL;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign q_out = (state == ISSUE) && (sel == S_Q);
  assign d_out = (state == ISSUE) && (sel == S_D);
  assign n_out = (state == ISSUE) && (sel == S_N);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign err   = (state == DONE) && (rem != '0);

`ifdef COIN_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      coin_count <= '0;
    else if (state == IDLE && start)
      coin_count <= '0;
    else if (state == ISSUE && coin_ack && coin_count != 8'hFF)
      coin_count <= coin_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_change_fsmd.sv
// Bench for change_fsmd: per-cycle output tables for timing plus a coin-event scoreboard.
// Build with +define+COIN_COUNT_EN to also check coin_count.
module tb_change_fsmd;
  logic       clk = 1'b0;
  logic       rst, start, coin_ack;
  logic [7:0] amount;
  logic       q_out, d_out, n_out, busy, done, err;
`ifdef COIN_COUNT_EN
  logic [7:0] coin_count;
`endif

  change_fsmd #(.W(8), .QVAL(25), .DVAL(10), .NVAL(5)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .coin_ack(coin_ack),
    .q_out(q_out), .d_out(d_out), .n_out(n_out), .busy(busy), .done(done), .err(err)
`ifdef COIN_COUNT_EN
    , .coin_count(coin_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // events: 0=Q 1=D 2=N 3=done/err0 4=done/err1
  int sb[$];
  bit mon_en = 0;
  logic pq = 0, pd = 0, pn = 0;

  task automatic push_txn(input int a);
    int r = a;
    while (r >= 5) begin
      if (r >= 25)      begin sb.push_back(0); r -= 25; end
      else if (r >= 10) begin sb.push_back(1); r -= 10; end
      else              begin sb.push_back(2); r -= 5;  end
    end
    sb.push_back(r != 0 ? 4 : 3);
  endtask

  task automatic sb_pop(input int ev);
    if (sb.size() == 0) chk("sb_unexpected", ev, 32'hFFFF);
    else chk("sb_event", ev, sb.pop_front());
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("excl", 32'(q_out) + 32'(d_out) + 32'(n_out) <= 1 ? 1 : 0, 1);
    if (q_out === 1'b1 && pq !== 1'b1) sb_pop(0);
    if (d_out === 1'b1 && pd !== 1'b1) sb_pop(1);
    if (n_out === 1'b1 && pn !== 1'b1) sb_pop(2);
    if (done === 1'b1) sb_pop(err === 1'b1 ? 4 : 3);
    pq = q_out; pd = d_out; pn = n_out;
  end

  // per-cycle tables, index i = cycle t+i after start accepted at edge t
  logic [5:0] expv [16];
  bit ackv [16], stv [16], rstv [16];
  logic [7:0] amtv [16];

  task automatic setup(input bit ack);
    for (int i = 0; i < 16; i++) begin
      expv[i] = '0; ackv[i] = ack; stv[i] = 0; rstv[i] = 0; amtv[i] = '0;
    end
  endtask

  task automatic run(input string tag, input int a, input int n);
    start = 1; amount = 8'(a); coin_ack = ackv[0];
    push_txn(a);
    @(posedge clk); #1;
    for (int i = 1; i <= n; i++) begin
      start = stv[i]; amount = amtv[i]; coin_ack = ackv[i]; rst = rstv[i];
      chk($sformatf("%s_c%0d", tag, i), {26'd0, q_out, d_out, n_out, busy, done, err}, {26'd0, expv[i]});
      @(posedge clk); #1;
    end
    start = 0; rst = 0; coin_ack = 0;
  endtask

  initial begin
    rst = 1; start = 0; coin_ack = 0; amount = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {26'd0, q_out, d_out, n_out, busy, done, err}, 0);
`ifdef COIN_COUNT_EN
    chk("rst_cnt", coin_count, 0);
`endif
    rst = 0;
    @(posedge clk); #1;
    mon_en = 1;

    // 40, ack high: Q, D, N with one SEL cycle between, done at t+8
    setup(1);
    expv[1] = 6'b000100; expv[2] = 6'b100100; expv[3] = 6'b000100; expv[4] = 6'b010100;
    expv[5] = 6'b000100; expv[6] = 6'b001100; expv[7] = 6'b000100; expv[8] = 6'b000110;
    expv[9] = 6'b000000;
    run("a40", 40, 9);
`ifdef COIN_COUNT_EN
    chk("a40_cnt", coin_count, 3);
`endif

    // 0: done at t+2; start during DONE is ignored
    setup(1);
    expv[1] = 6'b000100; expv[2] = 6'b000110; expv[3] = 6'b000000; expv[4] = 6'b000000;
    stv[2] = 1; amtv[2] = 8'd25;
    run("a0", 0, 4);
`ifdef COIN_COUNT_EN
    chk("a0_cnt", coin_count, 0);
`endif

    // 7: one nickel then done with residue error
    setup(1);
    expv[1] = 6'b000100; expv[2] = 6'b001100; expv[3] = 6'b000100; expv[4] = 6'b000111;
    expv[5] = 6'b000000;
    run("a7", 7, 5);
`ifdef COIN_COUNT_EN
    chk("a7_cnt", coin_count, 1);
`endif

    // 25, ack delayed: q held 4 cycles
    setup(0);
    ackv[5] = 1;
    expv[1] = 6'b000100; expv[2] = 6'b100100; expv[3] = 6'b100100; expv[4] = 6'b100100;
    expv[5] = 6'b100100; expv[6] = 6'b000100; expv[7] = 6'b000110; expv[8] = 6'b000000;
    run("a25", 25, 8);

    // 50 with a second start during ISSUE: ignored, rem not reloaded
    setup(1);
    stv[2] = 1; amtv[2] = 8'd10;
    expv[1] = 6'b000100; expv[2] = 6'b100100; expv[3] = 6'b000100; expv[4] = 6'b100100;
    expv[5] = 6'b000100; expv[6] = 6'b000110; expv[7] = 6'b000000;
    run("a50", 50, 7);
`ifdef COIN_COUNT_EN
    chk("a50_cnt", coin_count, 2);
`endif

    // 10, reset while d_out high: aborts with no done
    setup(0);
    rstv[2] = 1;
    expv[1] = 6'b000100; expv[2] = 6'b010100; expv[3] = 6'b000000; expv[4] = 6'b000000;
    run("rst", 10, 4);
    chk("rst_sb_left", sb.size(), 1);
    sb.delete();
`ifdef COIN_COUNT_EN
    chk("rst_cnt2", coin_count, 0);
`endif

    // 5 after abort: single nickel, normal done
    setup(1);
    expv[1] = 6'b000100; expv[2] = 6'b001100; expv[3] = 6'b000100; expv[4] = 6'b000110;
    expv[5] = 6'b000000;
    run("a5", 5, 5);
`ifdef COIN_COUNT_EN
    chk("a5_cnt", coin_count, 1);
`endif

    // random amounts with random ack latency, scoreboard-only, bounded wait
    for (int k = 0; k < 12; k++) begin
      int a = $urandom_range(0, 255);
      int cyc = 0;
      start = 1; amount = 8'(a); push_txn(a);
      @(posedge clk); #1;
      start = 0;
      while (busy === 1'b1 && cyc < 400) begin
        coin_ack = ($urandom_range(0, 2) == 0);
        @(posedge clk); #1;
        cyc++;
      end
      coin_ack = 0;
      if (cyc >= 400) chk("rand_timeout", 1, 0);
    end

    @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/change_fsmd.md
Name: change_fsmd

Overview:
FSMD that returns change, one coin at a time. It is the pay-out end of the vending coin interface: the coin-accept side counts inserted coins up to a cost, and this block takes an amount owed and issues coins to the dispensing mechanism. Coins are issued greedily (quarters, then dimes, then nickels) over a request/acknowledge handshake. Internally it is a remaining-amount datapath controlled by a small FSM.

Parameters:
W, 8, width of the amount and remaining-amount datapath
QVAL, 25, value of the large coin (quarter)
DVAL, 10, value of the medium coin (dime)
NVAL, 5, value of the small coin (nickel); QVAL > DVAL > NVAL > 0, all < 2^W

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  request a change transaction; sampled only in IDLE
amount  input  W  change owed; latched on accepted start
coin_ack  input  1  mechanism has taken the currently requested coin
q_out  output  1  request one large coin
d_out  output  1  request one medium coin
n_out  output  1  request one small coin
busy  output  1  transaction in progress (state != IDLE)
done  output  1  one-cycle pulse at end of transaction
err  output  1  residue error, valid with done

Behaviour:
- Single clock, synchronous active-high rst; all state updates on posedge clk.
- Reset: state=IDLE, rem=0, sel=none; q_out/d_out/n_out/busy/done/err all 0. Reset mid-transaction aborts immediately: any asserted coin request drops the next cycle and no done is issued.
- Datapath: register rem[W-1:0] and register sel (which coin is selected). rem loads amount on accepted start and subtracts the selected coin value on handshake. rem never underflows, because a coin is selected only when rem >= its value.
- States: IDLE, SEL, ISSUE, DONE.
- IDLE: busy=0. If start=1, load rem<=amount and go to SEL. Otherwise stay.
- SEL: busy=1, no coin outputs asserted.
  - rem>=QVAL: sel=Q, go to ISSUE.
  - else rem>=DVAL: sel=D, go to ISSUE.
  - else rem>=NVAL: sel=N, go to ISSUE.
  - else go to DONE.
- ISSUE: exactly one of q_out/d_out/n_out is high, matching sel (decoded from state and sel). It stays high until coin_ack=1 is sampled in ISSUE.
  - On ack: rem<=rem-value(sel), go to SEL, and the coin output is low next cycle.
  - coin_ack outside ISSUE is ignored.
- DONE: done=1 for exactly one cycle; err=1 in the same cycle if rem!=0 (amount not representable in NVAL units); busy=1. Next state IDLE.
- start while busy (any non-IDLE state) is ignored and has no effect on rem.
- Timing, with start accepted at edge t:
  - SEL occupies cycle t+1.
  - First coin request is high during cycle t+2.
  - Each coin costs 1 SEL cycle plus at least 1 ISSUE cycle.
  - amount=0 gives done in cycle t+2 with no coins.
- start in the same cycle that done is high is ignored (state is DONE). The earliest new start is accepted in the following IDLE cycle.
- Coin outputs are mutually exclusive at all times.

Optional Feature:
COIN_COUNT_EN
- Defined: adds output coin_count[7:0].
  - Cleared to 0 on accepted start.
  - Incremented on each ISSUE handshake, saturating at 255.
  - Holds its value through DONE and IDLE until the next start.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with amount=40 and coin_ack tied high → q_out, d_out, n_out pulse once each in that order, each pulse 1 cycle with 1 idle cycle between; done with err=0 in cycle t+8; coin_count=3 when enabled.
- amount=0 → no coin output asserted; done=1, err=0 in cycle t+2; busy high for cycles t+1..t+2 only.
- amount=7, ack immediate → a single n_out; then done with err=1 (rem=2).
- amount=25, coin_ack delayed 3 cycles → q_out held high for 4 consecutive cycles, drops the cycle after ack; done follows 2 cycles later.
- amount=50 with start pulsed again (amount=10) during the first ISSUE → exactly two q_out requests and no d_out; done err=0; rem not reloaded.
- rst asserted while d_out is high (amount=10) → the next cycle has all outputs 0, busy=0, no done pulse; a subsequent start with amount=5 yields a single n_out and a normal done.
